// File: rtl/if_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_fetch_unit_pipe_reg.sv
// IF/ID pipeline register: {instruction, PC+4} plus valid bit.
// Priority: flush (load a NOP bubble) > hold > load.
module if_id_pipe_reg
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc_4,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc_4,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc_4;
  logic        r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst  <= NOP_INST;
      r_pc_4  <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_inst  <= NOP_INST;
      r_pc_4  <= 32'h0;
      r_valid <= 1'b0;
    end else if (!i_hold && i_load) begin
      r_inst  <= i_inst;
      r_pc_4  <= i_pc_4;
      r_valid <= 1'b1;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc_4  = r_pc_4;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC register, fetch FSM, imem wait counter and sticky error flags.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_addr_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_4_out,
  output logic        if_id_valid,
  output logic        flush_id_ex,
  output logic        imem_timeout,
  output logic        misalign_err
);

  if_state_e   r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next, w_pc_4;
  logic [7:0]  r_wait_cnt, w_wait_next;
  logic        r_imem_req, r_flush_id_ex, r_imem_timeout, r_misalign_err;
  logic        w_pipe_hold, w_pipe_flush, w_pipe_load;
  logic        w_branch, w_timeout_set, w_misalign_set;

  assign w_pc_4 = r_pc + PC_INC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= BOOT;
      r_pc           <= RESET_PC;
      r_wait_cnt     <= 8'd0;
      r_imem_req     <= 1'b0;
      r_flush_id_ex  <= 1'b0;
      r_imem_timeout <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_wait_cnt     <= w_wait_next;
      r_imem_req     <= (w_state_next == FETCH);
      r_flush_id_ex  <= w_branch;
      r_imem_timeout <= r_imem_timeout | w_timeout_set;
      r_misalign_err <= r_misalign_err | w_misalign_set;
    end
  end

  // Priority per cycle: branch > stall > memory response.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_wait_next    = r_wait_cnt;
    w_pipe_hold    = 1'b1;
    w_pipe_flush   = 1'b0;
    w_pipe_load    = 1'b0;
    w_branch       = 1'b0;
    w_timeout_set  = 1'b0;
    w_misalign_set = 1'b0;
    case (r_state)
      BOOT: w_state_next = FETCH;
      FETCH, STALL: begin
        if (branch_taken_in) begin
          w_branch       = 1'b1;
          w_pc_next      = {branch_addr_in[31:2], 2'b00};
          w_misalign_set = (branch_addr_in[1:0] != 2'b00);
          w_pipe_flush   = 1'b1;
          w_wait_next    = 8'd0;
          w_state_next   = FETCH;
        end else if (stall_in) begin
          w_wait_next  = 8'd0;
          w_state_next = STALL;
        end else if (r_state == STALL) begin
          // Leaving STALL: the abandoned fetch re-issues at the same PC.
          w_wait_next  = 8'd0;
          w_state_next = FETCH;
        end else if (imem_ready) begin
          w_pipe_hold = 1'b0;
          w_pipe_load = 1'b1;
          w_pc_next   = w_pc_4;
          w_wait_next = 8'd0;
        end else begin
          w_pipe_flush  = 1'b1;
          w_wait_next   = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
          w_timeout_set = (w_wait_next >= 8'(MAX_WAIT));
        end
      end
      default: w_state_next = BOOT;
    endcase
  end

  if_id_pipe_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (w_pipe_hold),
    .i_flush (w_pipe_flush),
    .i_load  (w_pipe_load),
    .i_inst  (imem_rdata),
    .i_pc_4  (w_pc_4),
    .o_inst  (if_id_inst),
    .o_pc_4  (if_id_pc_4_out),
    .o_valid (if_id_valid)
  );

  assign pc_out       = r_pc;
  assign imem_addr    = r_pc;
  assign imem_req     = r_imem_req;
  assign flush_id_ex  = r_flush_id_ex;
  assign imem_timeout = r_imem_timeout;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns {16'hC0DE, addr[15:0]}.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, branch_taken_in, imem_ready;
  logic [31:0] branch_addr_in;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, pc_out;
  logic [31:0] if_id_inst, if_id_pc_4_out;
  logic        if_id_valid, flush_id_ex, imem_timeout, misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  if_fetch_unit #(.RESET_PC(32'h0000_0100), .MAX_WAIT(15)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .branch_taken_in (branch_taken_in),
    .branch_addr_in  (branch_addr_in),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .pc_out          (pc_out),
    .if_id_inst      (if_id_inst),
    .if_id_pc_4_out  (if_id_pc_4_out),
    .if_id_valid     (if_id_valid),
    .flush_id_ex     (flush_id_ex),
    .imem_timeout    (imem_timeout),
    .misalign_err    (misalign_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One line per observed cycle: PC, request, IF/ID contents, flush.
  task automatic chk_cycle(input string tag, input logic [31:0] pc, input logic req,
                           input logic [31:0] inst, input logic [31:0] pc4,
                           input logic vld, input logic fl);
    $display("%-10s pc=%h req=%0b inst=%h pc4=%h v=%0b fl=%0b",
             tag, pc_out, imem_req, if_id_inst, if_id_pc_4_out, if_id_valid, flush_id_ex);
    check_eq({tag, ".pc"},    pc_out,         pc);
    check_eq({tag, ".addr"},  imem_addr,      pc);
    check_eq({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    check_eq({tag, ".inst"},  if_id_inst,     inst);
    check_eq({tag, ".pc4"},   if_id_pc_4_out, pc4);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, vld});
    check_eq({tag, ".flush"}, {31'd0, flush_id_ex}, {31'd0, fl});
  endtask

  task automatic do_branch(input logic [31:0] target);
    branch_taken_in = 1'b1;
    branch_addr_in  = target;
    step();
    branch_taken_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0;
    branch_addr_in = 32'h0; imem_ready = 1'b1;
    step(); step();
    chk_cycle("reset", 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_eq("reset.tmo", {31'd0, imem_timeout}, 32'd0);
    check_eq("reset.mis", {31'd0, misalign_err}, 32'd0);

    // BOOT cycle, then back-to-back zero-wait fetches.
    rst = 1'b0;
    chk_cycle("boot", 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk_cycle("fetch0", 32'h100, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk_cycle("fetch1", 32'h104, 1'b1, 32'hC0DE_0100, 32'h104, 1'b1, 1'b0);
    step();
    chk_cycle("fetch2", 32'h108, 1'b1, 32'hC0DE_0104, 32'h108, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk_cycle("at120", 32'h120, 1'b1, 32'hC0DE_011C, 32'h120, 1'b1, 1'b0);

    // Taken branch: bubble + one-cycle flush.
    do_branch(32'h40);
    chk_cycle("br40", 32'h40, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk_cycle("br40+1", 32'h44, 1'b1, 32'hC0DE_0040, 32'h44, 1'b1, 1'b0);

    // Three-cycle stall at 0x200.
    do_branch(32'h1F8);
    step(); step();
    chk_cycle("pre_stl", 32'h200, 1'b1, 32'hC0DE_01FC, 32'h200, 1'b1, 1'b0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_cycle("stall", 32'h200, 1'b0, 32'hC0DE_01FC, 32'h200, 1'b1, 1'b0);
    end
    stall_in = 1'b0;
    step();
    chk_cycle("resume", 32'h200, 1'b1, 32'hC0DE_01FC, 32'h200, 1'b1, 1'b0);
    step();
    chk_cycle("resume+1", 32'h204, 1'b1, 32'hC0DE_0200, 32'h204, 1'b1, 1'b0);

    // Branch and stall together: branch wins.
    stall_in = 1'b1;
    do_branch(32'h80);
    stall_in = 1'b0;
    chk_cycle("br_stl", 32'h80, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk_cycle("br_stl+1", 32'h84, 1'b1, 32'hC0DE_0080, 32'h84, 1'b1, 1'b0);

    // Memory wait: 15 bubbles, timeout on the 15th.
    imem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk_cycle("wait", 32'h84, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      check_eq("wait.tmo", {31'd0, imem_timeout}, (i == 14) ? 32'd1 : 32'd0);
    end
    imem_ready = 1'b1;
    step();
    chk_cycle("ready", 32'h88, 1'b1, 32'hC0DE_0084, 32'h88, 1'b1, 1'b0);
    check_eq("sticky.tmo", {31'd0, imem_timeout}, 32'd1);

    // PC wrap-around.
    do_branch(32'hFFFF_FFFC);
    chk_cycle("brFFFC", 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk_cycle("wrap", 32'h0, 1'b1, 32'hC0DE_FFFC, 32'h0, 1'b1, 1'b0);
    check_eq("wrap.mis", {31'd0, misalign_err}, 32'd0);

    // Misaligned branch target.
    do_branch(32'h43);
    chk_cycle("br43", 32'h40, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("br43.mis", {31'd0, misalign_err}, 32'd1);

    // Async reset in the middle of a wait clears both flags.
    imem_ready = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk_cycle("mid_rst", 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_eq("rst.tmo", {31'd0, imem_timeout}, 32'd0);
    check_eq("rst.mis", {31'd0, misalign_err}, 32'd0);
    step();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
